tri_op_pipe: RTL and testbench

TRI_OP_PIPE -- requirements
Module: tri_op_pipe

---
 rtl/tri_op_pkg.sv | 19 +
 rtl/tri_op_alu.sv | 60 ++++++
 rtl/tri_op_pipe.sv | 121 ++++++++++++
 tb/tb_tri_op_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_op_pkg.sv
// -----------------------------------------------------------------------------
// tri_op_pkg
// Shared definitions for the tri_op_pipe block: the 2-bit operation-select
// encoding that travels with each operand set.
//
// Configuration macro used by this block: TRI_OP_SAT_EN (see tri_op_alu).
// -----------------------------------------------------------------------------
package tri_op_pkg;

    typedef enum logic [1:0] {
        MODE_SUM = 2'b00,  // a + b + c, overflow flagged
        MODE_MAX = 2'b01,  // unsigned maximum of the three operands
        MODE_MIN = 2'b10,  // unsigned minimum of the three operands
        MODE_MAJ = 2'b11   // bitwise majority vote
    } tri_mode_t;

    localparam int MODE_W = 2;

endpackage

// File: rtl/tri_op_alu.sv
// -----------------------------------------------------------------------------
// tri_op_alu
// Purely combinational three-operand operation unit.
//
// Ports:
//   a, b, c  in  [WIDTH-1:0]  operands
//   mode     in  [1:0]        operation select (tri_mode_t encoding)
//   o        out [WIDTH-1:0]  result
//   ovf      out              true sum did not fit in WIDTH bits (SUM only)
//
// Configuration:
//   TRI_OP_SAT_EN  defined   -> SUM saturates to all-ones on overflow
//                  undefined -> SUM wraps (low WIDTH bits of the true sum)
// -----------------------------------------------------------------------------
module tri_op_alu
    import tri_op_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] o,
    output logic             ovf
);

    // Two extra bits hold the worst case 3*(2^WIDTH-1) without loss.
    logic [WIDTH+1:0] sum;
    logic             sum_ovf;
    logic [WIDTH-1:0] max_ab;
    logic [WIDTH-1:0] min_ab;
    tri_mode_t        op;

    assign sum     = {2'b00, a} + {2'b00, b} + {2'b00, c};
    assign sum_ovf = |sum[WIDTH+1:WIDTH];
    assign max_ab  = (a > b) ? a : b;
    assign min_ab  = (a < b) ? a : b;
    assign op      = tri_mode_t'(mode);

    always_comb begin
        o   = '0;
        ovf = 1'b0;
        case (op)
            MODE_SUM: begin
                ovf = sum_ovf;
`ifdef TRI_OP_SAT_EN
                o   = sum_ovf ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                o   = sum[WIDTH-1:0];
`endif
            end
            MODE_MAX: o = (max_ab > c) ? max_ab : c;
            MODE_MIN: o = (min_ab < c) ? min_ab : c;
            MODE_MAJ: o = (a & b) | (a & c) | (b & c);
            default:  o = '0;
        endcase
    end

endmodule

// File: rtl/tri_op_pipe.sv
// -----------------------------------------------------------------------------
// tri_op_pipe
// Two-stage valid/ready pipeline around tri_op_alu.
//   S1 registers the operand set (a, b, c, mode).
//   S2 registers the ALU result (o, ovf) and drives out_valid.
// With no back-pressure a set accepted in cycle N appears on out_valid in
// cycle N+2, and one set per cycle can be sustained.
//
// Ports:
//   clk        in                 rising-edge clock
//   rst_n      in                 asynchronous active-low reset
//   in_valid   in                 operand set valid
//   in_ready   out                block accepts an operand set this cycle
//   a, b, c    in  [WIDTH-1:0]    operands
//   mode       in  [1:0]          operation select, sampled with the operands
//   out_valid  out                result valid
//   out_ready  in                 downstream accepts the result
//   o          out [WIDTH-1:0]    result
//   ovf        out                SUM overflow flag (0 for other modes)
//   count      out [CNT_W-1:0]    operand sets accepted since reset (wraps)
//
// Configuration macro: TRI_OP_SAT_EN (saturating SUM, handled in tri_op_alu).
// -----------------------------------------------------------------------------
module tri_op_pipe
    import tri_op_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             ovf,
    output logic [CNT_W-1:0] count
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high. A producer holding valid keeps its data stable until the
    // transfer; this block never drops out_valid or changes o/ovf while a
    // result is waiting (out_valid=1, out_ready=0).

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] s1_c;
    logic [1:0]       s1_mode;

    logic [WIDTH-1:0] alu_o;
    logic             alu_ovf;

    logic             s2_adv;
    logic             accept;

    // S2 may take new contents when it is empty or its result leaves now.
    assign s2_adv   = !out_valid || out_ready;
    // S1 has room when empty or when its content moves into S2 this edge.
    assign in_ready = !s1_valid || s2_adv;
    assign accept   = in_valid && in_ready;

    tri_op_alu #(.WIDTH(WIDTH)) u_alu (
        .a    (s1_a),
        .b    (s1_b),
        .c    (s1_c),
        .mode (s1_mode),
        .o    (alu_o),
        .ovf  (alu_ovf)
    );

    // Stage 1: operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_mode  <= MODE_SUM;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= a;
            s1_b     <= b;
            s1_c     <= c;
            s1_mode  <= mode;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: result registers. Payload only loads on a real set so a
    // bubble leaves the last result visible but invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            o         <= '0;
            ovf       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                o   <= alu_o;
                ovf <= alu_ovf;
            end
        end
    end

    // Accepted-set counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (accept) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_tri_op_pipe.sv
// -----------------------------------------------------------------------------
// tb_tri_op_pipe
// Self-checking bench for tri_op_pipe (WIDTH=3, CNT_W=4 so the counter wraps).
// A reference model computes each result from the operation definitions with
// integer arithmetic; a scoreboard queue tracks sets in flight, their results
// and the edge on which they were accepted.
// Honours TRI_OP_SAT_EN for the expected SUM behaviour.
// -----------------------------------------------------------------------------
module tb_tri_op_pipe;

  localparam int WIDTH = 3;
  localparam int CNT_W = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef TRI_OP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] o;
  logic             ovf;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  tri_op_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .ovf       (ovf),
    .count     (count)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {ovf, o}.
  function automatic logic [WIDTH:0] ref_op(input int va, input int vb, input int vc, input int vm);
    int r;
    int s;
    int ones;
    bit v;
    r = 0;
    v = 1'b0;
    case (vm)
      0: begin
        s = va + vb + vc;
        v = (s > MAXV);
        r = (v && SAT) ? MAXV : (s % (MAXV + 1));
      end
      1: begin
        r = va;
        if (vb > r) r = vb;
        if (vc > r) r = vc;
      end
      2: begin
        r = va;
        if (vb < r) r = vb;
        if (vc < r) r = vc;
      end
      default: begin
        for (int i = 0; i < WIDTH; i++) begin
          ones = ((va >> i) & 1) + ((vb >> i) & 1) + ((vc >> i) & 1);
          if (ones >= 2) r = r | (1 << i);
        end
      end
    endcase
    return {v, r[WIDTH-1:0]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [WIDTH:0] exp_q[$];
  int             acc_q[$];   // edge index on which each queued set was accepted
  int             model_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_count", count, 0);
      exp_q.delete();
      acc_q.delete();
      model_cnt = 0;
    end else begin
      // Two storage slots: with two sets in flight the input is only open
      // when the head result leaves this cycle.
      check("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
      // The oldest set is presented one edge after its acceptance edge.
      check("out_valid", out_valid, (exp_q.size() > 0) && (cyc >= acc_q[0] + 1));
      if (out_valid && exp_q.size() > 0) begin
        check("o", o, exp_q[0][WIDTH-1:0]);
        check("ovf", ovf, exp_q[0][WIDTH]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      check("count", count, model_cnt);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_op(a, b, c, mode));
        acc_q.push_back(cyc + 1);
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_set(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic [WIDTH-1:0] vc, input logic [1:0] vm);
    bit done;
    done = 1'b0;
    a = va; b = vb; c = vc; mode = vm;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("push_timeout", 0, 1);
  endtask

  // Single set through an idle pipe with out_ready=1: exact 2-cycle latency.
  task automatic run_vec(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic [WIDTH-1:0] vc, input logic [1:0] vm,
                         input logic [WIDTH-1:0] eo, input logic eovf);
    a = va; b = vb; c = vc; mode = vm;
    in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_accept"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1_valid"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_lat2_valid"}, out_valid, 1);
    check({tag, "_o"}, o, eo);
    check({tag, "_ovf"}, ovf, eovf);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] e_first;
  logic [WIDTH:0]   r_tmp;
  bit               acc;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; c = '0; mode = 2'b00;
    #1;
    check("init_out_valid", out_valid, 0);
    check("init_count", count, 0);
    check("init_o", o, 0);
    check("init_ovf", ovf, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed operation vectors.
    out_ready = 1'b1;
    run_vec("sum_small", 3'b000, 3'b001, 3'b010, 2'b00, 3'b011, 1'b0);
    run_vec("sum_ovf15", 3'b101, 3'b011, 3'b111, 2'b00, 3'b111, 1'b1);
    run_vec("sum_ovf18", 3'b110, 3'b110, 3'b110, 2'b00, SAT ? 3'b111 : 3'b010, 1'b1);
    run_vec("max",       3'b100, 3'b111, 3'b110, 2'b01, 3'b111, 1'b0);
    run_vec("min",       3'b100, 3'b111, 3'b110, 2'b10, 3'b100, 1'b0);
    run_vec("maj",       3'b100, 3'b111, 3'b110, 2'b11, 3'b110, 1'b0);

    // Back-pressure: four sets with the output blocked.
    do_reset();
    out_ready = 1'b0;
    r_tmp = ref_op(1, 2, 3, 0);
    e_first = r_tmp[WIDTH-1:0];
    push_set(3'd1, 3'd2, 3'd3, 2'b00);
    push_set(3'd7, 3'd2, 3'd5, 2'b01);
    a = 3'd6; b = 3'd3; c = 3'd1; mode = 2'b10;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_o_held", o, e_first);
      check("bp_count", count, 2);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    push_set(3'd6, 3'd3, 3'd1, 2'b10);
    push_set(3'd5, 3'd3, 3'd6, 2'b11);
    drain("bp");
    @(negedge clk);
    check("bp_count_final", count, 4);
    @(posedge clk);
    #1;

    // Randomized traffic with random back-pressure.
    in_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = WIDTH'($urandom_range(0, MAXV));
        b = WIDTH'($urandom_range(0, MAXV));
        c = WIDTH'($urandom_range(0, MAXV));
        mode = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    drain("rand");

    // Reset with both stages full.
    out_ready = 1'b0;
    push_set(3'd2, 3'd2, 3'd2, 2'b00);
    push_set(3'd4, 3'd1, 3'd0, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_count", count, 0);
    check("midrst_o", o, 0);
    check("midrst_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_stale", out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
